// File: rtl/fifo_register_if.sv
// Handshake and status bundle for fifo_register.
// The producer/consumer side uses the master modport; the FIFO itself uses slave.
interface fifo_register_if #(
    parameter int N     = 4,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic          enable;
    logic          clear;
    logic          push;
    logic [N-1:0]  d;
    logic          pop;
    logic [N-1:0]  q;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport master (
        output enable, clear, push, d, pop,
        input  q, empty, full, count, overflow, underflow
    );

    modport slave (
        input  enable, clear, push, d, pop,
        output q, empty, full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_register.sv
// Synchronous first-word-fall-through FIFO of DEPTH words of N bits.
// Push/pop handshakes, count-derived full/empty, sticky overflow/underflow
// flags, global enable and a synchronous flush (clear) that beats push/pop.
// Control state resets asynchronously; the storage array is never reset and
// is hidden behind q=0 whenever the FIFO is empty.
module fifo_register #(
    parameter  int N     = 4,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    fifo_register_if.slave    bus
);

    localparam logic [AW:0] ZERO_COUNT = {(AW+1){1'b0}};
    localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // Pointer advance; DEPTH is a power of two so the natural wrap is modulo DEPTH.
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return p + AW'(1);
    endfunction

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_empty;
    logic          w_full;
    logic          w_active;
    logic          w_pop_ok;
    logic          w_push_ok;
    logic          w_overflow_set;
    logic          w_underflow_set;
    logic [N-1:0]  w_q;

    // Status is derived from the count only, so it can never disagree with it.
    assign w_empty  = (r_count == ZERO_COUNT);
    assign w_full   = (r_count == FULL_COUNT);

    // An operation only counts when the block is enabled and not being flushed.
    assign w_active        = bus.enable & ~bus.clear;
    assign w_pop_ok        = w_active & bus.pop & ~w_empty;
    // A pop in the same cycle frees a slot, so a push on full is still accepted.
    assign w_push_ok       = w_active & bus.push & (~w_full | w_pop_ok);
    assign w_overflow_set  = w_active & bus.push & w_full & ~w_pop_ok;
    assign w_underflow_set = w_active & bus.pop & w_empty;

    // Storage write; data only, deliberately without reset.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= bus.d;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd        <= {AW{1'b0}};
            r_wr        <= {AW{1'b0}};
            r_count     <= ZERO_COUNT;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.enable) begin
            if (bus.clear) begin
                r_rd        <= {AW{1'b0}};
                r_wr        <= {AW{1'b0}};
                r_count     <= ZERO_COUNT;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (w_push_ok) begin
                    r_wr <= ptr_next(r_wr);
                end else begin
                    r_wr <= r_wr;
                end
                if (w_pop_ok) begin
                    r_rd <= ptr_next(r_rd);
                end else begin
                    r_rd <= r_rd;
                end
                case ({w_push_ok, w_pop_ok})
                    2'b10:   r_count <= r_count + ONE_COUNT;
                    2'b01:   r_count <= r_count - ONE_COUNT;
                    default: r_count <= r_count;
                endcase
                r_overflow  <= r_overflow  | w_overflow_set;
                r_underflow <= r_underflow | w_underflow_set;
            end
        end else begin
            r_rd        <= r_rd;
            r_wr        <= r_wr;
            r_count     <= r_count;
            r_overflow  <= r_overflow;
            r_underflow <= r_underflow;
        end
    end

    // Head word presented combinationally from registered state; zero when empty.
    always_comb begin
        w_q = {N{1'b0}};
        if (w_empty) begin
            w_q = {N{1'b0}};
        end else begin
            w_q = r_mem[r_rd];
        end
    end

    assign bus.q         = w_q;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_fifo_register.sv
// Self-checking bench for fifo_register: a DEPTH=4 instance driven from a
// vector table with a data scoreboard, and a DEPTH=2 instance exercised by a
// hand-written wrap/overflow/clear sequence.
module tb_fifo_register;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_register_if #(.N(4), .DEPTH(4)) bus_a ();
    fifo_register_if #(.N(4), .DEPTH(2)) bus_b ();

    fifo_register #(.N(4), .DEPTH(4)) dut_a (.clock(clk), .reset(rst), .bus(bus_a));
    fifo_register #(.N(4), .DEPTH(2)) dut_b (.clock(clk), .reset(rst), .bus(bus_b));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       en, clr, push, pop;
        logic [3:0] d;
        logic [2:0] cnt;
        logic [3:0] q;
        logic       emp, ful, ovf, unf;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic en, clr, push, pop, input logic [3:0] d,
                                input logic [2:0] cnt, input logic [3:0] q,
                                input logic emp, ful, ovf, unf);
        vec_t v;
        v.en = en; v.clr = clr; v.push = push; v.pop = pop; v.d = d;
        v.cnt = cnt; v.q = q; v.emp = emp; v.ful = ful; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk_a(input string tag, input logic [2:0] cnt, input logic [3:0] q,
                         input logic emp, ful, ovf, unf);
        chk({tag, ".count"},     32'(bus_a.count),     32'(cnt));
        chk({tag, ".q"},         32'(bus_a.q),         32'(q));
        chk({tag, ".empty"},     32'(bus_a.empty),     32'(emp));
        chk({tag, ".full"},      32'(bus_a.full),      32'(ful));
        chk({tag, ".overflow"},  32'(bus_a.overflow),  32'(ovf));
        chk({tag, ".underflow"}, 32'(bus_a.underflow), 32'(unf));
    endtask

    task automatic chk_b(input string tag, input logic [1:0] cnt, input logic [3:0] q,
                         input logic emp, ovf, unf);
        chk({tag, ".count"},     32'(bus_b.count),     32'(cnt));
        chk({tag, ".q"},         32'(bus_b.q),         32'(q));
        chk({tag, ".empty"},     32'(bus_b.empty),     32'(emp));
        chk({tag, ".overflow"},  32'(bus_b.overflow),  32'(ovf));
        chk({tag, ".underflow"}, 32'(bus_b.underflow), 32'(unf));
    endtask

    // Drive one cycle on instance B (inputs set after negedge, checked 1 time unit after posedge).
    task automatic step_b(input logic clr, push, pop, input logic [3:0] d);
        @(negedge clk);
        bus_b.enable = 1'b1; bus_b.clear = clr; bus_b.push = push; bus_b.pop = pop; bus_b.d = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.enable = 1'b0; bus_a.clear = 1'b0; bus_a.push = 1'b0; bus_a.pop = 1'b0; bus_a.d = 4'h0;
        bus_b.enable = 1'b0; bus_b.clear = 1'b0; bus_b.push = 1'b0; bus_b.pop = 1'b0; bus_b.d = 4'h0;

        // Vector table: en clr push pop d | count q empty full ovf unf
        // Fill and overflow
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,4'h1, 3'd1,4'h1,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,4'h2, 3'd2,4'h1,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,4'h3, 3'd3,4'h1,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,4'h4, 3'd4,4'h1,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,4'h5, 3'd4,4'h1,1'b0,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,4'h0, 3'd3,4'h2,1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,4'h0, 3'd2,4'h3,1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,4'h0, 3'd1,4'h4,1'b0,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,4'h0, 3'd0,4'h0,1'b1,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,4'h0, 3'd0,4'h0,1'b1,1'b0,1'b0,1'b0));
        // Simultaneous push/pop on full
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,4'h1, 3'd1,4'h1,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,4'h2, 3'd2,4'h1,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,4'h3, 3'd3,4'h1,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,4'h4, 3'd4,4'h1,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b1,4'h9, 3'd4,4'h2,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,4'h0, 3'd3,4'h3,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,4'h0, 3'd2,4'h4,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,4'h0, 3'd1,4'h9,1'b0,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b1,4'h0, 3'd0,4'h0,1'b1,1'b0,1'b0,1'b0));
        // Underflow with simultaneous push
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b1,4'h7, 3'd1,4'h7,1'b0,1'b0,1'b0,1'b1));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,4'h8, 3'd2,4'h7,1'b0,1'b0,1'b0,1'b1));
        vecs.push_back(mk(1'b1,1'b0,1'b1,1'b0,4'h6, 3'd3,4'h7,1'b0,1'b0,1'b0,1'b1));
        // Enable low freezes everything, including clear
        vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,4'hF, 3'd3,4'h7,1'b0,1'b0,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,4'hE, 3'd3,4'h7,1'b0,1'b0,1'b0,1'b1));

        // Reset state while reset is held
        repeat (2) @(negedge clk);
        chk_a("reset", 3'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            logic pop_ok, push_ok;
            @(negedge clk);
            bus_a.enable = vecs[i].en; bus_a.clear = vecs[i].clr;
            bus_a.push = vecs[i].push; bus_a.pop = vecs[i].pop; bus_a.d = vecs[i].d;
            #1;
            // Scoreboard: an effective pop must present the oldest accepted word.
            pop_ok  = vecs[i].en & ~vecs[i].clr & vecs[i].pop & (sb.size() > 0);
            push_ok = vecs[i].en & ~vecs[i].clr & vecs[i].push & ((sb.size() < 4) | pop_ok);
            if (pop_ok) begin
                chk($sformatf("sb_pop[%0d]", i), 32'(bus_a.q), 32'(sb.pop_front()));
            end
            if (push_ok) sb.push_back(vecs[i].d);
            if (vecs[i].en & vecs[i].clr) sb.delete();
            @(posedge clk);
            #1;
            chk_a($sformatf("vec[%0d]", i), vecs[i].cnt, vecs[i].q,
                  vecs[i].emp, vecs[i].ful, vecs[i].ovf, vecs[i].unf);
            chk($sformatf("sb_count[%0d]", i), 32'(bus_a.count), 32'(sb.size()));
        end

        // Asynchronous reset pulse between edges with 3 entries held
        @(negedge clk);
        bus_a.enable = 1'b1; bus_a.clear = 1'b0; bus_a.push = 1'b0; bus_a.pop = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk_a("async_rst", 3'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        sb.delete();
        // First push on the edge right after reset release
        bus_a.push = 1'b1; bus_a.d = 4'h3;
        @(posedge clk);
        #1;
        bus_a.push = 1'b0;
        chk_a("post_rst_push", 3'd1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);

        // DEPTH=2: five push/pop pairs, pointers wrap every second access
        for (int i = 0; i < 5; i++) begin
            logic [3:0] v;
            v = 4'hA + 4'(i);
            step_b(1'b0, 1'b1, 1'b0, v);
            chk_b($sformatf("wrap_push[%0d]", i), 2'd1, v, 1'b0, 1'b0, 1'b0);
            step_b(1'b0, 1'b0, 1'b1, 4'h0);
            chk_b($sformatf("wrap_pop[%0d]", i), 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        end
        // Fill, overflow and underflow on DEPTH=2, then clear with push
        step_b(1'b0, 1'b1, 1'b0, 4'h1);
        step_b(1'b0, 1'b1, 1'b0, 4'h2);
        chk("b_full", 32'(bus_b.full), 32'd1);
        step_b(1'b0, 1'b1, 1'b0, 4'h3);
        chk_b("b_ovf", 2'd2, 4'h1, 1'b0, 1'b1, 1'b0);
        step_b(1'b0, 1'b0, 1'b1, 4'h0);
        step_b(1'b0, 1'b0, 1'b1, 4'h0);
        step_b(1'b0, 1'b0, 1'b1, 4'h0);
        chk_b("b_unf", 2'd0, 4'h0, 1'b1, 1'b1, 1'b1);
        step_b(1'b1, 1'b1, 1'b0, 4'h5);
        chk_b("b_clear", 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        step_b(1'b0, 1'b0, 1'b0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
